// File: rtl/hummingbird_core_p.sv
// Hummingbird accumulator core.
// Each instruction is two memory words: an opcode word and an operand word.
// Both are fetched over a simple req/ack memory port, and the instruction
// then executes. Memory instructions do one extra transaction while they execute.
// Any number of wait states is allowed on every transaction.

module hummingbird_core_p #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [ADDR_W-1:0] pc_out,
   output logic [DATA_W-1:0] a_out,
   output logic [1:0]        flags_out,
   output logic [2:0]        state_out,
   output logic              hlt_out
);

   typedef enum logic [2:0] {
      ST_F0   = 3'd0,
      ST_F1   = 3'd1,
      ST_EX   = 3'd2,
      ST_HALT = 3'd3
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [ADDR_W-1:0] r_pc;
   logic [DATA_W-1:0] r_acc;
   logic              r_carry;
   logic              r_zero;
   logic [DATA_W-1:0] r_ir0;
   logic [DATA_W-1:0] r_ir1;

   logic [3:0]        w_opcode;
   logic [ADDR_W-1:0] w_ea;
   logic              w_isMemOp;
   logic              w_ackd;
   logic              w_exDone;
   logic [DATA_W:0]   w_sum;
   logic [DATA_W:0]   w_diff;
   logic [DATA_W-1:0] w_result;
   logic              w_carryOut;
   logic              w_writeAcc;
   logic              w_updCarry;

   assign w_opcode  = r_ir0[DATA_W-1 -: 4];
   assign w_isMemOp = (w_opcode >= 4'h2) && (w_opcode <= 4'h8);
   assign w_ackd    = mem_req & mem_ack;
   assign w_exDone  = (r_state == ST_EX) && (!w_isMemOp || w_ackd);

   // The effective address takes its high bits from the low bits of the
   // opcode word. When the address is no wider than a data word, the
   // operand word alone is the effective address.
   generate
      if (ADDR_W == DATA_W) begin : g_eaNarrow
         assign w_ea = r_ir1;
      end else begin : g_eaWide
         assign w_ea = {r_ir0[ADDR_W-DATA_W-1:0], r_ir1};
      end
   endgenerate

   assign pc_out    = r_pc;
   assign a_out     = r_acc;
   assign flags_out = {r_carry, r_zero};
   assign state_out = r_state;
   assign hlt_out   = (r_state == ST_HALT);

   // Memory request decode: fetches read at pc, and memory ops use ea while
   // they execute. Every field comes from registers, so it stays stable until
   // the ack. The request is suppressed while reset is high.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = r_pc;
      mem_wdata = r_acc;
      case (r_state)
         ST_F0, ST_F1: mem_req = 1'b1;
         ST_EX: begin
            if (w_isMemOp) begin
               mem_req  = 1'b1;
               mem_addr = w_ea;
               mem_we   = (w_opcode == 4'h3);
            end
         end
         default: ;
      endcase
      if (rst) begin
         mem_req = 1'b0;
         mem_we  = 1'b0;
      end
   end

   // ALU: add and subtract are done one bit wider than the data word.
   // The extra bit is the carry for add and the borrow (A < M) for subtract.
   always_comb begin
      w_sum      = {1'b0, r_acc} + {1'b0, mem_rdata};
      w_diff     = {1'b0, r_acc} - {1'b0, mem_rdata};
      w_result   = r_acc;
      w_carryOut = r_carry;
      w_writeAcc = 1'b0;
      w_updCarry = 1'b0;
      case (w_opcode)
         4'h1: begin w_result = r_ir1;               w_writeAcc = 1'b1; end
         4'h2: begin w_result = mem_rdata;           w_writeAcc = 1'b1; end
         4'h4: begin
            w_result   = w_sum[DATA_W-1:0];
            w_carryOut = w_sum[DATA_W];
            w_writeAcc = 1'b1;
            w_updCarry = 1'b1;
         end
         4'h5: begin
            w_result   = w_diff[DATA_W-1:0];
            w_carryOut = w_diff[DATA_W];
            w_writeAcc = 1'b1;
            w_updCarry = 1'b1;
         end
         4'h6: begin w_result = r_acc & mem_rdata;   w_writeAcc = 1'b1; end
         4'h7: begin w_result = r_acc | mem_rdata;   w_writeAcc = 1'b1; end
         4'h8: begin w_result = r_acc ^ mem_rdata;   w_writeAcc = 1'b1; end
         4'h9: begin
            w_sum      = {1'b0, r_acc} + {1'b0, r_ir1};
            w_result   = w_sum[DATA_W-1:0];
            w_carryOut = w_sum[DATA_W];
            w_writeAcc = 1'b1;
            w_updCarry = 1'b1;
         end
         default: ;
      endcase
   end

   // Next-state logic: a fetch or memory operation leaves its state only in
   // its ack cycle. Other instructions leave execute after one cycle.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_F0: if (w_ackd) w_nextState = ST_F1;
         ST_F1: if (w_ackd) w_nextState = ST_EX;
         ST_EX: begin
            if (w_exDone) begin
               w_nextState = (w_opcode == 4'hF) ? ST_HALT : ST_F0;
            end
         end
         ST_HALT: w_nextState = ST_HALT;
         default: w_nextState = ST_F0;
      endcase
   end

   // State register. Reset wins over everything, including an unacked
   // transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_F0;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Datapath: latch the fetched words, advance pc, and retire the executed
   // instruction. Jumps test the flags as they stood before execute. A taken
   // jump replaces the pc value that was already advanced past the operand.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc    <= '0;
         r_acc   <= '0;
         r_carry <= 1'b0;
         r_zero  <= 1'b0;
         r_ir0   <= '0;
         r_ir1   <= '0;
      end else begin
         case (r_state)
            ST_F0: begin
               if (w_ackd) begin
                  r_ir0 <= mem_rdata;
                  r_pc  <= r_pc + ADDR_W'(1);
               end
            end
            ST_F1: begin
               if (w_ackd) begin
                  r_ir1 <= mem_rdata;
                  r_pc  <= r_pc + ADDR_W'(1);
               end
            end
            ST_EX: begin
               if (w_exDone) begin
                  if (w_writeAcc) begin
                     r_acc  <= w_result;
                     r_zero <= (w_result == '0);
                  end
                  if (w_updCarry) begin
                     r_carry <= w_carryOut;
                  end
                  case (w_opcode)
                     4'hA: r_pc <= w_ea;
                     4'hB: if (r_zero)  r_pc <= w_ea;
                     4'hC: if (r_carry) r_pc <= w_ea;
                     default: ;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hummingbird_core_p.sv
// Directed testbench for the hummingbird core.
// One 8/12 instance runs against a byte memory model whose ack can be
// returned at once or held off by hand. A second 16/20 instance runs against
// a small fixed ROM to exercise the wide effective address.

module tb_hummingbird_core_p;

   logic        clk = 1'b0;
   logic        rst;
   logic        rst16;

   logic        memReq;
   logic        memWe;
   logic [11:0] memAddr;
   logic [7:0]  memWdata;
   logic [7:0]  memRdata;
   logic        memAck;
   logic [11:0] pcOut;
   logic [7:0]  aOut;
   logic [1:0]  flagsOut;
   logic [2:0]  stateOut;
   logic        hltOut;

   logic        memReq16;
   logic        memWe16;
   logic [19:0] memAddr16;
   logic [15:0] memWdata16;
   logic [15:0] memRdata16;
   logic        memAck16;
   logic [19:0] pcOut16;
   logic [15:0] aOut16;
   logic [1:0]  flagsOut16;
   logic [2:0]  stateOut16;
   logic        hltOut16;

   logic [7:0]  mem [0:4095];
   bit          ackManual;
   bit          ackManualVal;
   int          writeCount = 0;
   int          testCount  = 0;
   int          failCount  = 0;
   int          writesBefore;

   hummingbird_core_p #(.DATA_W(8), .ADDR_W(12)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_req   (memReq),
      .mem_we    (memWe),
      .mem_addr  (memAddr),
      .mem_wdata (memWdata),
      .mem_rdata (memRdata),
      .mem_ack   (memAck),
      .pc_out    (pcOut),
      .a_out     (aOut),
      .flags_out (flagsOut),
      .state_out (stateOut),
      .hlt_out   (hltOut)
   );

   hummingbird_core_p #(.DATA_W(16), .ADDR_W(20)) dut16 (
      .clk       (clk),
      .rst       (rst16),
      .mem_req   (memReq16),
      .mem_we    (memWe16),
      .mem_addr  (memAddr16),
      .mem_wdata (memWdata16),
      .mem_rdata (memRdata16),
      .mem_ack   (memAck16),
      .pc_out    (pcOut16),
      .a_out     (aOut16),
      .flags_out (flagsOut16),
      .state_out (stateOut16),
      .hlt_out   (hltOut16)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // 8-bit memory model: reads are combinational, and ack is either immediate
   // or held under manual control
   assign memRdata = mem[memAddr];
   assign memAck   = ackManual ? ackManualVal : memReq;

   // Commit writes and count them so that a repeated write would show up
   always @(posedge clk) begin
      if (memReq && memWe && memAck) begin
         mem[memAddr] <= memWdata;
         writeCount   <= writeCount + 1;
      end
   end

   // 16-bit ROM: LDI 0x1234 ; LD ea=0xABCDE (holds 0) ; HLT elsewhere
   always_comb begin
      case (memAddr16)
         20'h00000: memRdata16 = 16'h1000;
         20'h00001: memRdata16 = 16'h1234;
         20'h00002: memRdata16 = 16'h200A;
         20'h00003: memRdata16 = 16'hBCDE;
         20'hABCDE: memRdata16 = 16'h0000;
         default:   memRdata16 = 16'hF000;
      endcase
   end
   assign memAck16 = memReq16;

   // Advance a number of clock cycles, leaving time at the falling edge
   task automatic applyStimulus(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   // Compare one observed value against its hand-computed expected value
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Directed test sequence
   initial begin
      rst          = 1'b1;
      rst16        = 1'b1;
      ackManual    = 1'b0;
      ackManualVal = 1'b0;
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

      // LDI 0x05 ; ADDI 0xFB ; HLT
      mem[0] = 8'h10; mem[1] = 8'h05;
      mem[2] = 8'h90; mem[3] = 8'hFB;
      mem[4] = 8'hF0; mem[5] = 8'h00;
      applyStimulus(2);
      checkOutput("rst_pc",    pcOut,    0);
      checkOutput("rst_a",     aOut,     0);
      checkOutput("rst_flags", flagsOut, 0);
      checkOutput("rst_state", stateOut, 0);
      checkOutput("rst_req",   memReq,   0);
      checkOutput("rst_hlt",   hltOut,   0);
      rst = 1'b0;
      #1;
      checkOutput("first_req",  memReq,  1);
      checkOutput("first_addr", memAddr, 0);
      applyStimulus(3);
      checkOutput("ldi_a",     aOut,     8'h05);
      checkOutput("ldi_pc",    pcOut,    2);
      checkOutput("ldi_state", stateOut, 0);
      checkOutput("ldi_flags", flagsOut, 2'b00);
      applyStimulus(3);
      checkOutput("addi_a",     aOut,     8'h00);
      checkOutput("addi_flags", flagsOut, 2'b11);
      checkOutput("addi_pc",    pcOut,    4);
      applyStimulus(3);
      checkOutput("hlt_state", stateOut, 3);
      checkOutput("hlt_out",   hltOut,   1);
      for (int i = 0; i < 10; i++) begin
         checkOutput("hlt_req",   memReq, 0);
         checkOutput("hlt_frozen_pc", pcOut, 6);
         applyStimulus(1);
      end
      checkOutput("hlt_frozen_a", aOut, 8'h00);
      rst = 1'b1;
      applyStimulus(1);
      checkOutput("hlt_rst_pc",    pcOut,    0);
      checkOutput("hlt_rst_state", stateOut, 0);
      checkOutput("hlt_rst_hlt",   hltOut,   0);

      // LDI 0xA5 ; ST ea=0x123 with the ack held off for four cycles
      mem[0] = 8'h10; mem[1] = 8'hA5;
      mem[2] = 8'h31; mem[3] = 8'h23;
      mem[12'h123] = 8'h00;
      rst = 1'b0;
      applyStimulus(5);
      ackManual    = 1'b1;
      ackManualVal = 1'b0;
      writesBefore = writeCount;
      for (int i = 0; i < 4; i++) begin
         checkOutput("st_wait_bus",   {memReq, memWe, memAddr, memWdata}, {1'b1, 1'b1, 12'h123, 8'hA5});
         checkOutput("st_wait_state", stateOut, 2);
         applyStimulus(1);
      end
      ackManualVal = 1'b1;
      checkOutput("st_ack_bus", {memReq, memWe, memAddr, memWdata}, {1'b1, 1'b1, 12'h123, 8'hA5});
      applyStimulus(1);
      ackManualVal = 1'b0;
      ackManual    = 1'b0;
      checkOutput("st_writes", writeCount - writesBefore, 1);
      checkOutput("st_mem",    mem[12'h123], 8'hA5);
      checkOutput("st_state",  stateOut, 0);
      checkOutput("st_pc",     pcOut,    4);

      // LDI 0x10 ; SUB M[0x050]=0x20 ; JC 0x200
      rst = 1'b1;
      applyStimulus(1);
      mem[0] = 8'h10; mem[1] = 8'h10;
      mem[2] = 8'h50; mem[3] = 8'h50;
      mem[4] = 8'hC2; mem[5] = 8'h00;
      mem[12'h050] = 8'h20;
      rst = 1'b0;
      applyStimulus(3);
      checkOutput("sub_pre_a", aOut, 8'h10);
      applyStimulus(3);
      checkOutput("sub_a",     aOut,     8'hF0);
      checkOutput("sub_flags", flagsOut, 2'b10);
      applyStimulus(3);
      checkOutput("jc_pc",    pcOut,    12'h200);
      checkOutput("jc_state", stateOut, 0);

      // JMP 0xFFE ; JZ 0x345 with Z=0 at the top of memory
      rst = 1'b1;
      applyStimulus(1);
      mem[0] = 8'hAF; mem[1] = 8'hFE;
      mem[12'hFFE] = 8'hB3; mem[12'hFFF] = 8'h45;
      rst = 1'b0;
      applyStimulus(3);
      checkOutput("jmp_pc", pcOut, 12'hFFE);
      applyStimulus(3);
      checkOutput("jz_wrap_pc", pcOut,    12'h000);
      checkOutput("jz_state",   stateOut, 0);

      // Reset in the middle of an unacked operand fetch
      rst = 1'b1;
      applyStimulus(1);
      mem[0] = 8'h10; mem[1] = 8'h77;
      rst = 1'b0;
      applyStimulus(1);
      checkOutput("midf1_state", stateOut, 1);
      checkOutput("midf1_pc",    pcOut,    1);
      ackManual    = 1'b1;
      ackManualVal = 1'b0;
      applyStimulus(2);
      checkOutput("midf1_wait_state", stateOut, 1);
      checkOutput("midf1_wait_addr",  memAddr,  1);
      rst = 1'b1;
      applyStimulus(1);
      checkOutput("midf1_rst_state", stateOut, 0);
      checkOutput("midf1_rst_req",   memReq,   0);
      ackManualVal = 1'b1;
      applyStimulus(1);
      checkOutput("midf1_ackpulse_state", stateOut, 0);
      checkOutput("midf1_ackpulse_pc",    pcOut,    0);
      checkOutput("midf1_ackpulse_a",     aOut,     0);
      ackManualVal = 1'b0;
      ackManual    = 1'b0;
      rst = 1'b0;
      applyStimulus(3);
      checkOutput("midf1_refetch_a",  aOut,  8'h77);
      checkOutput("midf1_refetch_pc", pcOut, 2);

      // Wide instance: LDI 0x1234 ; LD ea=0xABCDE
      rst16 = 1'b0;
      applyStimulus(3);
      checkOutput("w16_ldi_a", aOut16, 16'h1234);
      applyStimulus(2);
      checkOutput("w16_ld_state", stateOut16, 2);
      checkOutput("w16_ld_addr",  memAddr16,  20'hABCDE);
      checkOutput("w16_ld_req",   {memReq16, memWe16}, 2'b10);
      applyStimulus(1);
      checkOutput("w16_ld_a",     aOut16,     16'h0000);
      checkOutput("w16_ld_flags", flagsOut16, 2'b01);
      checkOutput("w16_ld_pc",    pcOut16,    20'h4);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/hummingbird_core_p.md
HUMMINGBIRD_CORE_P -- requirements
Module: hummingbird_core_p

Interface
REQ-001 SHALL have parameter DATA_W, default 8, accumulator/memory word width; legal range 8..16.
REQ-002 SHALL have parameter ADDR_W, default 12, memory address width; legal range DATA_W..2*DATA_W-4.
REQ-003 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-005 SHALL have port mem_req  output  1  memory transaction request.
REQ-006 SHALL have port mem_we  output  1  1 = write, 0 = read; valid while mem_req.
REQ-007 SHALL have port mem_addr  output  ADDR_W  transaction address; valid while mem_req.
REQ-008 SHALL have port mem_wdata  output  DATA_W  write data; valid while mem_req & mem_we.
REQ-009 SHALL have port mem_rdata  input  DATA_W  read data; sampled in the ack cycle.
REQ-010 SHALL have port mem_ack  input  1  transaction completes in any cycle with mem_req & mem_ack.
REQ-011 SHALL have ports pc_out (ADDR_W), a_out (DATA_W), flags_out (2, {C,Z}) and state_out (3), all outputs mirroring internal registers.
REQ-012 SHALL have port hlt_out  output  1  high while in HALT.

Function
REQ-013 SHALL implement states F0=0 (fetch opcode word), F1=1 (fetch operand word), EX=2 (execute), HALT=3; state_out carries the encoding.
REQ-014 SHALL hold mem_req, mem_we, mem_addr and mem_wdata stable from assertion until the ack cycle; it SHALL leave the state only in the ack cycle; wait states are unbounded.
REQ-015 SHALL, in F0/F1, issue a read at pc, latch mem_rdata into IR0 or IR1 on ack, increment pc by 1 modulo 2^ADDR_W on ack, and move F0->F1 and F1->EX.
REQ-016 SHALL take opcode = IR0[DATA_W-1:DATA_W-4], imm = IR1, ea = {IR0[ADDR_W-DATA_W-1:0], IR1}, with ea = IR1 when ADDR_W = DATA_W.
REQ-017 SHALL execute opcodes 0 NOP, 1 LDI A=imm, 2 LD A=M[ea], 3 ST M[ea]=A, 4 ADD A+=M[ea], 5 SUB A-=M[ea], 6 AND, 7 OR, 8 XOR (A op= M[ea]), 9 ADDI A+=imm, A JMP pc=ea, B JZ (pc=ea if Z), C JC (pc=ea if C), D and E as NOP, F HLT.
REQ-018 SHALL complete opcodes 2-8 in EX in the cycle of the read or write ack; all other opcodes complete in EX in one cycle with mem_req low.
REQ-019 SHALL go EX->F0 after completion, except HLT, which goes EX->HALT.
REQ-020 SHALL keep HALT until rst, with mem_req low, hlt_out=1 and registers frozen.
REQ-021 SHALL compute arithmetic in DATA_W+1 bits: ADD/ADDI set C = carry out; SUB sets C = 1 iff A < M (borrow); results are truncated to DATA_W.
REQ-022 SHALL set Z = (result == 0) for opcodes 1, 2, 4-9; opcodes 1, 2, 6, 7, 8 leave C unchanged; opcodes 0, 3, A-F leave both flags unchanged.
REQ-023 SHALL evaluate JZ/JC with flag values before EX; a taken jump overrides the F1 increment; a not-taken jump leaves pc = instruction address + 2.
REQ-024 SHALL drive mem_we=1 only in EX for ST, with mem_wdata = A.

Reset
REQ-025 SHALL, on rst sampled high, set pc=0, A=0, C=0, Z=0, IR0=IR1=0 and state=F0, and drive mem_req=0 in the reset cycle and hlt_out=0.
REQ-026 SHALL let rst take priority over any state, including a pending unacked transaction, which is abandoned without completing.
REQ-027 SHALL assert mem_req for the fetch at address 0 in the first cycle after rst deasserts.

Verification
REQ-028 SHALL be verified by: LDI 0x05; ADDI 0xFB with zero-wait memory -> A=0x00, Z=1, C=1; each instruction takes 3 cycles; pc=4.
REQ-029 SHALL be verified by: ST 0x3 ea=0x123 with A=0xA5, ack withheld 4 cycles -> mem_we=1, addr=0x123, wdata=0xA5 stable for 5 cycles; single write.
REQ-030 SHALL be verified by: A=0x10, SUB M=0x20 -> A=0xF0, C=1, Z=0; then JC 0x200 -> pc=0x200.
REQ-031 SHALL be verified by: JZ with Z=0 at pc=0xFFE -> not taken, pc wraps to 0x000.
REQ-032 SHALL be verified by: HLT -> state=3, hlt_out=1, mem_req=0 for 10 cycles; rst -> pc=0, state=0.
REQ-033 SHALL be verified by: rst asserted mid-F1 with ack low, then ack pulsed -> IR1 unchanged, state=F0, pc=0.
REQ-034 SHALL be verified by: DATA_W=16, ADDR_W=20: LD ea=0xABCDE -> mem_addr=0xABCDE; A=M, Z updated.
